knn_dist_stream: RTL and testbench

Parametrised multi-lane distance engine for the KNN classifier datapath: on `start` it sweeps a runtime-selected number of training samples from an external registered memory, LANES samples per cycle. It computes squared-Euclidean (L2²) or Manhattan (L1) distance to a latched query point. Each beat it emits one distance, class and valid bit per lane, in a flat stream that feeds the downstream k-selection block. Successor to the fixed two-lane, fixed-length, Euclidean-only engine; it adds lane count, width, depth and metric parameters, a tail mask, query latching and clean restart.

---
 rtl/knn_dist_stream.sv | 187 ++++++++++++++++++
 tb/tb_knn_dist_stream.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/knn_dist_stream.sv
// Multi-lane KNN distance engine: sweeps LANES training samples per cycle from a
// registered memory and streams per-lane L2-squared or L1 distances to a latched query.
module knn_dist_stream #(
  parameter int LANES   = 2,
  parameter int COORD_W = 8,
  parameter int CLASS_W = 2,
  parameter int ADDR_W  = 10
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    start,
  input  logic                                    mode,
  input  logic [ADDR_W:0]                         num_samples,
  input  logic [COORD_W-1:0]                      x_in,
  input  logic [COORD_W-1:0]                      y_in,
  output logic                                    mem_en,
  output logic [ADDR_W-1:0]                       mem_addr,
  input  logic [LANES*(2*COORD_W+CLASS_W)-1:0]    mem_data,
  output logic                                    out_valid,
  output logic [LANES-1:0]                        out_mask,
  output logic [LANES*(2*COORD_W+3)-1:0]          out_dist,
  output logic [LANES*CLASS_W-1:0]                out_class,
  output logic [ADDR_W-1:0]                       out_index,
  output logic                                    busy,
  output logic                                    done,
  output logic [1:0]                              fsm_state
);

  localparam int SAMP_W = 2*COORD_W + CLASS_W;
  localparam int DIST_W = 2*COORD_W + 3;
  localparam int TERM_W = 2*COORD_W + 2;
  localparam int CW1    = COORD_W + 1;
  localparam int AW1    = ADDR_W + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

  // Handshake: a beat is presented when out_valid is high and is consumed in that
  // same cycle; there is no ready, so the consumer must take every beat.
  state_t state;

  logic [COORD_W-1:0] x_q, y_q;
  logic               mode_q;
  logic [ADDR_W:0]    num_q;

  logic               s0_v, s1_v, s2_v;
  logic [LANES-1:0]   s0_mask, s1_mask, s2_mask;
  logic [ADDR_W-1:0]  s0_idx, s1_idx, s2_idx;
  logic [CW1-1:0]     s1_dx [LANES];
  logic [CW1-1:0]     s1_dy [LANES];
  logic [CLASS_W-1:0] s1_cls [LANES];
  logic [TERM_W-1:0]  s2_a [LANES];
  logic [TERM_W-1:0]  s2_b [LANES];
  logic [CLASS_W-1:0] s2_cls [LANES];

  logic               last_read;
  logic [LANES-1:0]   rd_mask;
  logic [CW1-1:0]     d_x [LANES];
  logic [CW1-1:0]     d_y [LANES];
  logic [CLASS_W-1:0] t_cls [LANES];
  logic [CW1-1:0]     abs_x [LANES];
  logic [CW1-1:0]     abs_y [LANES];
  logic [TERM_W-1:0]  term_a [LANES];
  logic [TERM_W-1:0]  term_b [LANES];

  assign fsm_state = state;

  always_comb begin
    last_read = ({1'b0, mem_addr} + AW1'(LANES)) >= num_q;
    rd_mask   = '0;
    for (int i = 0; i < LANES; i++) begin
      // Lanes beyond num_samples (including those wrapping past memory end) are masked.
      rd_mask[i] = ({1'b0, mem_addr} + AW1'(i)) < num_q;
      d_x[i]   = {x_q[COORD_W-1], x_q}
               - {mem_data[i*SAMP_W + SAMP_W - 1], mem_data[i*SAMP_W + CLASS_W + COORD_W +: COORD_W]};
      d_y[i]   = {y_q[COORD_W-1], y_q}
               - {mem_data[i*SAMP_W + CLASS_W + COORD_W - 1], mem_data[i*SAMP_W + CLASS_W +: COORD_W]};
      t_cls[i] = mem_data[i*SAMP_W +: CLASS_W];
      abs_x[i] = s1_dx[i][COORD_W] ? (~s1_dx[i] + CW1'(1)) : s1_dx[i];
      abs_y[i] = s1_dy[i][COORD_W] ? (~s1_dy[i] + CW1'(1)) : s1_dy[i];
      term_a[i] = mode_q ? TERM_W'(abs_x[i]) : TERM_W'(abs_x[i]) * TERM_W'(abs_x[i]);
      term_b[i] = mode_q ? TERM_W'(abs_y[i]) : TERM_W'(abs_y[i]) * TERM_W'(abs_y[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      mem_en   <= 1'b0;
      mem_addr <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      mode_q   <= 1'b0;
      num_q    <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        x_q      <= x_in;
        y_q      <= y_in;
        mode_q   <= mode;
        num_q    <= num_samples;
        mem_addr <= '0;
        busy     <= 1'b1;
        if (num_samples == '0) begin
          state  <= DRAIN;
          mem_en <= 1'b0;
        end else begin
          state  <= RUN;
          mem_en <= 1'b1;
        end
      end else begin
        case (state)
          RUN: begin
            if (last_read) begin
              mem_en <= 1'b0;
              state  <= DRAIN;
            end else begin
              mem_addr <= mem_addr + ADDR_W'(LANES);
            end
          end
          DRAIN: begin
            // The last beat sits in the output register this cycle; done follows it.
            if (!s0_v && !s1_v && !s2_v) begin
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Start flushes every stage so no beat of an aborted sweep escapes.
  always_ff @(posedge clk) begin
    if (reset || start) begin
      s0_v      <= 1'b0;
      s1_v      <= 1'b0;
      s2_v      <= 1'b0;
      s0_mask   <= '0;
      s1_mask   <= '0;
      s2_mask   <= '0;
      s0_idx    <= '0;
      s1_idx    <= '0;
      s2_idx    <= '0;
      out_valid <= 1'b0;
      out_mask  <= '0;
      out_dist  <= '0;
      out_class <= '0;
      out_index <= '0;
      for (int i = 0; i < LANES; i++) begin
        s1_dx[i]  <= '0;
        s1_dy[i]  <= '0;
        s1_cls[i] <= '0;
        s2_a[i]   <= '0;
        s2_b[i]   <= '0;
        s2_cls[i] <= '0;
      end
    end else begin
      s0_v      <= mem_en;
      s0_mask   <= mem_en ? rd_mask : '0;
      s0_idx    <= mem_addr;
      s1_v      <= s0_v;
      s1_mask   <= s0_mask;
      s1_idx    <= s0_idx;
      s2_v      <= s1_v;
      s2_mask   <= s1_mask;
      s2_idx    <= s1_idx;
      out_valid <= s2_v;
      out_mask  <= s2_mask;
      out_index <= s2_idx;
      for (int i = 0; i < LANES; i++) begin
        s1_dx[i]  <= d_x[i];
        s1_dy[i]  <= d_y[i];
        s1_cls[i] <= t_cls[i];
        s2_a[i]   <= term_a[i];
        s2_b[i]   <= term_b[i];
        s2_cls[i] <= s1_cls[i];
        out_dist[i*DIST_W +: DIST_W]   <= s2_mask[i] ? (DIST_W'(s2_a[i]) + DIST_W'(s2_b[i])) : '0;
        out_class[i*CLASS_W +: CLASS_W] <= s2_mask[i] ? s2_cls[i] : '0;
      end
    end
  end

endmodule

// File: tb/tb_knn_dist_stream.sv
// Directed bench for knn_dist_stream: a sweep table run against 2- and 4-lane
// instances, plus hand-written abort, back-to-back start and mid-run reset sequences.
module tb_knn_dist_stream;

  localparam int DW = 19;

  logic        clk;
  logic        reset;
  logic        start2, start4;
  logic        mode;
  logic [10:0] num_samples;
  logic [7:0]  x_in, y_in;

  logic        mem_en2, ov2, busy2, done2;
  logic [9:0]  addr2, idx2;
  logic [35:0] data2;
  logic [1:0]  mask2, st2;
  logic [37:0] dist2;
  logic [3:0]  cls2;

  logic        mem_en4, ov4, busy4, done4;
  logic [9:0]  addr4, idx4;
  logic [71:0] data4;
  logic [3:0]  mask4;
  logic [1:0]  st4;
  logic [75:0] dist4;
  logic [7:0]  cls4;

  logic [17:0] mem [1024];

  int checks   = 0;
  int failures = 0;
  logic sel4 = 1'b0;

  knn_dist_stream #(.LANES(2)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .mode(mode), .num_samples(num_samples),
    .x_in(x_in), .y_in(y_in), .mem_en(mem_en2), .mem_addr(addr2), .mem_data(data2),
    .out_valid(ov2), .out_mask(mask2), .out_dist(dist2), .out_class(cls2),
    .out_index(idx2), .busy(busy2), .done(done2), .fsm_state(st2)
  );

  knn_dist_stream #(.LANES(4)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .mode(mode), .num_samples(num_samples),
    .x_in(x_in), .y_in(y_in), .mem_en(mem_en4), .mem_addr(addr4), .mem_data(data4),
    .out_valid(ov4), .out_mask(mask4), .out_dist(dist4), .out_class(cls4),
    .out_index(idx4), .busy(busy4), .done(done4), .fsm_state(st4)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // registered memory models, data valid the cycle after mem_en
  initial begin
    data2 = '0;
    data4 = '0;
  end
  always @(posedge clk) begin
    if (mem_en2)
      for (int i = 0; i < 2; i++) data2[i*18 +: 18] <= mem[(int'(addr2) + i) & 1023];
    if (mem_en4)
      for (int i = 0; i < 4; i++) data4[i*18 +: 18] <= mem[(int'(addr4) + i) & 1023];
  end

  logic         mon_valid, mon_done, mon_busy, mon_mem_en;
  logic [7:0]   mon_mask;
  logic [151:0] mon_dist;
  logic [15:0]  mon_cls;
  logic [9:0]   mon_idx;
  assign mon_valid  = sel4 ? ov4 : ov2;
  assign mon_done   = sel4 ? done4 : done2;
  assign mon_busy   = sel4 ? busy4 : busy2;
  assign mon_mem_en = sel4 ? mem_en4 : mem_en2;
  assign mon_mask   = sel4 ? {4'b0, mask4} : {6'b0, mask2};
  assign mon_dist   = sel4 ? {76'b0, dist4} : {114'b0, dist2};
  assign mon_cls    = sel4 ? {8'b0, cls4} : {12'b0, cls2};
  assign mon_idx    = sel4 ? idx4 : idx2;

  // scoreboard
  task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic int model_dist(input bit md, input int qx, input int qy, input int idx);
    int sx, sy, dx, dy;
    sx = $signed(mem[idx][17:10]);
    sy = $signed(mem[idx][9:2]);
    dx = qx - sx;
    dy = qy - sy;
    if (md) return (dx < 0 ? -dx : dx) + (dy < 0 ? -dy : dy);
    return dx*dx + dy*dy;
  endfunction

  // driver: called at a negedge, returns at the negedge of the first cycle after start
  task automatic start_sweep(input bit s4, input bit md, input int qx, input int qy, input int n);
    sel4        = s4;
    mode        = md;
    x_in        = 8'(qx);
    y_in        = 8'(qy);
    num_samples = 11'(n);
    if (s4) start4 = 1'b1;
    else    start2 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start2 = 1'b0;
    start4 = 1'b0;
  endtask

  // monitor one sweep from cycle t; every beat is compared against the model
  task automatic watch(input string tag, input int lanes, input bit md, input int qx, input int qy,
                       input int n, input int exp_beats, input int exp_done,
                       input int spot_beat, input int spot_lane, output int spot_got);
    int beats, got_done, ix;
    logic [255:0] exp_v, got_v;
    logic [7:0]   e_mask;
    logic [151:0] e_dist;
    logic [15:0]  e_cls;
    beats    = 0;
    got_done = -1;
    spot_got = -1;
    check({tag, "_busy_t"}, 256'(mon_busy), 256'(1));
    check({tag, "_memen_t"}, 256'(mon_mem_en), 256'(n > 0));
    for (int k = 0; k < 1100; k++) begin
      if (mon_valid) begin
        e_mask = '0;
        e_dist = '0;
        e_cls  = '0;
        for (int i = 0; i < lanes; i++) begin
          ix = beats*lanes + i;
          if (ix < n) begin
            e_mask[i]          = 1'b1;
            e_dist[i*DW +: DW] = DW'(model_dist(md, qx, qy, ix));
            e_cls[i*2 +: 2]    = mem[ix][1:0];
          end
        end
        exp_v = 256'({10'(beats*lanes), e_mask, e_cls, e_dist});
        got_v = 256'({mon_idx, mon_mask, mon_cls, mon_dist});
        check($sformatf("%s_beat%0d", tag, beats), got_v, exp_v);
        check($sformatf("%s_lat%0d", tag, beats), 256'(k), 256'(beats + 4));
        if (beats == spot_beat) spot_got = int'(mon_dist[spot_lane*DW +: DW]);
        beats++;
      end
      if (mon_done) begin
        got_done = k;
        check({tag, "_busy_at_done"}, 256'(mon_busy), 256'(0));
        break;
      end
      @(negedge clk);
    end
    check({tag, "_done_cycle"}, 256'(got_done), 256'(exp_done));
    check({tag, "_beats"}, 256'(beats), 256'(exp_beats));
  endtask

  typedef struct {
    bit use4;
    bit md;
    int qx, qy, n;
    int exp_beats, exp_done;
    int spot_beat, spot_lane, spot_dist;
  } vec_t;

  initial begin
    vec_t vecs[6];
    int   sg, stray, k;

    vecs[0] = '{0, 0,    0,    0, 1024, 512, 516, 0, 1,     2};
    vecs[1] = '{0, 1, -128, -128,    6,   3,   7, 2, 1,   510};
    vecs[2] = '{0, 0,  127, -128,    7,   4,   8, 0, 0, 32258};
    vecs[3] = '{1, 0,    3,   -2,   10,   3,   7, 2, 3,     0};
    vecs[4] = '{1, 1,   -1,    5,    1,   1,   5, 0, 0,     7};
    vecs[5] = '{0, 1,    0,    0,    0,   0,   1, -1, 0,    0};

    for (int i = 0; i < 1024; i++) mem[i] = {i[7:0], 8'hFF, i[1:0]};
    mem[5] = {8'sd127, 8'sd127, 2'd1};

    reset = 1'b1; start2 = 1'b0; start4 = 1'b0; mode = 1'b0;
    num_samples = '0; x_in = '0; y_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_dut2", 256'({mem_en2, addr2, ov2, mask2, dist2, cls2, idx2, busy2, done2, st2}), 256'(0));
    check("reset_dut4", 256'({mem_en4, addr4, ov4, mask4, dist4, cls4, idx4, busy4, done4, st4}), 256'(0));
    reset = 1'b0;
    @(negedge clk);

    // table-driven sweeps
    for (int v = 0; v < 6; v++) begin
      start_sweep(vecs[v].use4, vecs[v].md, vecs[v].qx, vecs[v].qy, vecs[v].n);
      watch($sformatf("vec%0d", v), vecs[v].use4 ? 4 : 2, vecs[v].md, vecs[v].qx, vecs[v].qy,
            vecs[v].n, vecs[v].exp_beats, vecs[v].exp_done,
            vecs[v].spot_beat, vecs[v].spot_lane, sg);
      if (vecs[v].spot_beat >= 0)
        check($sformatf("vec%0d_spot", v), 256'(sg), 256'(vecs[v].spot_dist));
    end

    // abort: second start three cycles in, inputs scrambled right after it
    @(negedge clk);
    start_sweep(0, 0, 0, 0, 20);
    @(negedge clk);
    @(negedge clk);
    start_sweep(0, 1, 2, 3, 8);
    mode = 1'b0; x_in = 8'd206; y_in = 8'd9; num_samples = 11'd3;
    watch("abort", 2, 1, 2, 3, 8, 4, 8, -1, 0, sg);
    stray = 0;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      if (ov2 || done2) stray++;
    end
    check("abort_stray", 256'(stray), 256'(0));

    // start in the same cycle as the previous sweep's done
    start_sweep(0, 0, 0, 0, 2);
    k = 0;
    while (!done2 && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("coinc_done_cycle", 256'(k), 256'(5));
    start_sweep(0, 1, -5, 7, 3);
    watch("coinc_new", 2, 1, -5, 7, 3, 2, 6, -1, 0, sg);

    // reset in the middle of a run
    @(negedge clk);
    start_sweep(0, 0, 1, 1, 100);
    repeat (5) @(negedge clk);
    check("midrun_valid", 256'(ov2), 256'(1));
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrun_reset", 256'({mem_en2, addr2, ov2, mask2, dist2, cls2, idx2, busy2, done2, st2}), 256'(0));
    reset = 1'b0;
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
